// File: rtl/config_word_packer.sv
// config_word_packer
//   Front end of the configuration port. It packs a byte stream (Mode=0) or
//   takes a 32-bit parallel stream (Mode=1) and emits aligned 32-bit words,
//   each with a one-cycle WriteStrobe. ComActive marks an active session and
//   drops after TimeoutCycles idle cycles. Any partial word is discarded when
//   the session ends, so the next session starts 4-byte aligned.
//   Optional feature macro: CONFIG_CHECKSUM_EN (running byte checksum).
//   Without it, Checksum is tied to zero.
module config_word_packer #(
   parameter int TimeoutCycles = 1000000,
   parameter int TimeoutWidth  = 20
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        Mode,
   input  logic [7:0]  RxByte,
   input  logic        RxValid,
   input  logic [31:0] ParWord,
   input  logic        ParStrobe,
   output logic [31:0] WriteData,
   output logic        WriteStrobe,
   output logic        ComActive,
   output logic [31:0] Checksum
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   // The session ends on the last idle cycle, when the counter is about to
   // reach TimeoutCycles. ComActive is then low in the following cycle.
   localparam logic [TimeoutWidth-1:0] TIMEOUT_LAST = TimeoutWidth'(TimeoutCycles - 1);
   localparam logic [TimeoutWidth-1:0] CNT_ONE      = TimeoutWidth'(1);
   localparam logic [TimeoutWidth-1:0] CNT_MAX      = '1;

   state_t                  state;
   logic [TimeoutWidth-1:0] idle_cnt;
   logic [1:0]              byte_idx;
   logic [23:0]             byte_shift;
   logic                    mode_q;

   logic                    accept_p0;
   logic                    mode_changed;
   logic [1:0]              eff_idx;
   logic                    timeout_hit;

   // Qualify the input selected by Mode. Detect a Mode change and the idle timeout.
   always_comb begin
      accept_p0    = Mode ? ParStrobe : RxValid;
      mode_changed = (Mode != mode_q);
      eff_idx      = mode_changed ? 2'd0 : byte_idx;
      timeout_hit  = (state == S_ACTIVE) && !accept_p0 && (idle_cnt == TIMEOUT_LAST);
   end

   assign ComActive = (state == S_ACTIVE);

   // Session FSM, idle counter, byte packing and the registered word outputs
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         idle_cnt    <= '0;
         byte_idx    <= 2'd0;
         byte_shift  <= 24'd0;
         mode_q      <= 1'b0;
         WriteData   <= 32'd0;
         WriteStrobe <= 1'b0;
      end else begin
         WriteStrobe <= 1'b0;
         mode_q      <= Mode;

         case (state)
            S_IDLE:   if (accept_p0) state <= S_ACTIVE;
            S_ACTIVE: if (timeout_hit) state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase

         // Any accepted input restarts the count. Outside a session the counter rests at 0.
         if (accept_p0 || (state != S_ACTIVE) || timeout_hit) begin
            idle_cnt <= '0;
         end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + CNT_ONE;
         end

         if (timeout_hit) begin
            byte_idx <= 2'd0;
         end else if (accept_p0 && !Mode) begin
            // Big-endian: the first byte of a word ends up in WriteData[31:24]
            if (eff_idx == 2'd3) begin
               WriteData   <= {byte_shift, RxByte};
               WriteStrobe <= 1'b1;
            end else begin
               byte_shift <= {byte_shift[15:0], RxByte};
            end
            byte_idx <= eff_idx + 2'd1;
         end else if (accept_p0 && Mode) begin
            WriteData   <= ParWord;
            WriteStrobe <= 1'b1;
            if (mode_changed) byte_idx <= 2'd0;
         end else if (mode_changed) begin
            byte_idx <= 2'd0;
         end
      end
   end

`ifdef CONFIG_CHECKSUM_EN
   logic [31:0] chk_sum;
   logic [31:0] chk_add;

   function automatic logic [31:0] word_byte_sum(input logic [31:0] w);
      return {24'd0, w[31:24]} + {24'd0, w[23:16]} + {24'd0, w[15:8]} + {24'd0, w[7:0]};
   endfunction

   // Contribution of the accepted input to the checksum
   always_comb begin
      chk_add = Mode ? word_byte_sum(ParWord) : {24'd0, RxByte};
   end

   // Restart the sum at the start of a session. Hold it while idle so it can be read afterwards.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         chk_sum <= 32'd0;
      end else if (accept_p0) begin
         chk_sum <= (state == S_IDLE) ? chk_add : chk_sum + chk_add;
      end
   end

   assign Checksum = chk_sum;
`else
   assign Checksum = 32'h0;
`endif

endmodule

// File: tb/tb_config_word_packer.sv
// Testbench for config_word_packer. It runs directed scenarios and randomized
// streams. A queue-based model of the session, packing and checksum rules
// provides the expected values for the randomized streams.
module tb_config_word_packer;

   localparam int TO = 16;

   logic        clk;
   logic        resetn;
   logic        mode;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [31:0] par_word;
   logic        par_strobe;
   logic [31:0] write_data;
   logic        write_strobe;
   logic        com_active;
   logic [31:0] checksum;

   int checks;
   int failures;

   // Reference model state
   logic        m_active;
   int          m_silent;
   logic [7:0]  byte_q[$];
   logic [31:0] m_data;
   logic        m_strobe;
   logic [31:0] m_sum;
   logic        m_mode_prev;

   config_word_packer #(.TimeoutCycles(TO), .TimeoutWidth(5)) dut (
      .CLK(clk), .resetn(resetn), .Mode(mode), .RxByte(rx_byte), .RxValid(rx_valid),
      .ParWord(par_word), .ParStrobe(par_strobe), .WriteData(write_data),
      .WriteStrobe(write_strobe), .ComActive(com_active), .Checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish got=running exp=finished");
      $fatal(1);
   end

   function automatic logic [31:0] exp_chk();
`ifdef CONFIG_CHECKSUM_EN
      return m_sum;
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_reset();
      m_active    = 1'b0;
      m_silent    = 0;
      byte_q.delete();
      m_data      = 32'h0;
      m_strobe    = 1'b0;
      m_sum       = 32'h0;
      m_mode_prev = 1'b0;
   endtask

   // Apply the session rules to the inputs present during the current cycle.
   task automatic model_step();
      logic acc;
      acc = mode ? par_strobe : rx_valid;
      m_strobe = 1'b0;
      if (mode != m_mode_prev) byte_q.delete();
      m_mode_prev = mode;
      if (acc) begin
         if (!m_active) m_sum = 32'h0;
         m_active = 1'b1;
         m_silent = 0;
         if (mode) begin
            m_data   = par_word;
            m_strobe = 1'b1;
            m_sum    = m_sum + 32'(par_word[31:24]) + 32'(par_word[23:16])
                             + 32'(par_word[15:8]) + 32'(par_word[7:0]);
         end else begin
            byte_q.push_back(rx_byte);
            m_sum = m_sum + 32'(rx_byte);
            if (byte_q.size() == 4) begin
               m_data   = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
               m_strobe = 1'b1;
               byte_q.delete();
            end
         end
      end else if (m_active) begin
         m_silent++;
         if (m_silent == TO) begin
            m_active = 1'b0;
            m_silent = 0;
            byte_q.delete();
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Idle the inputs until the modelled session has ended (bounded).
   task automatic go_idle();
      rx_valid   = 1'b0;
      par_strobe = 1'b0;
      for (int k = 0; k < 40 && m_active; k++) tick();
      tick();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #12;
      checks++; if (write_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", write_data, 32'h0); end
      checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", write_strobe); end
      checks++; if (com_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", com_active); end
      checks++; if (checksum !== 32'h0) begin failures++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
      model_reset();
      @(posedge clk);
      #3 resetn = 1'b1;
   endtask

   task automatic test_byte_basic();
      logic [7:0] seq [4];
      seq = '{8'hFA, 8'hB0, 8'hFA, 8'hB1};
      for (int i = 0; i < 4; i++) begin
         rx_byte = seq[i]; rx_valid = 1'b1;
         tick();
         checks++; if (com_active !== 1'b1) begin failures++; $display("FAIL basic_active byte=%0d got=%b exp=1", i, com_active); end
         checks++; if (write_strobe !== (i == 3)) begin failures++; $display("FAIL basic_strobe byte=%0d got=%b exp=%b", i, write_strobe, (i == 3)); end
      end
      checks++; if (write_data !== 32'hFAB0_FAB1) begin failures++; $display("FAIL basic_data got=%h exp=%h", write_data, 32'hFAB0_FAB1); end
      rx_valid = 1'b0; rx_byte = 8'($urandom);
      tick();
      checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL basic_single_strobe got=%b exp=0", write_strobe); end
      checks++; if (write_data !== 32'hFAB0_FAB1) begin failures++; $display("FAIL basic_hold got=%h exp=%h", write_data, 32'hFAB0_FAB1); end
   endtask

   task automatic test_timeout();
      int strobes;
      int fall_at;
      logic [7:0] seq [4];
      logic [31:0] first_word;
      strobes = 0; fall_at = -1;
      go_idle();
      checks++; if (com_active !== 1'b0) begin failures++; $display("FAIL timeout_pre_idle got=%b exp=0", com_active); end
      for (int i = 0; i < 6; i++) begin
         rx_byte = 8'($urandom); rx_valid = 1'b1;
         if (i == 0) first_word[31:24] = rx_byte;
         if (i == 1) first_word[23:16] = rx_byte;
         if (i == 2) first_word[15:8]  = rx_byte;
         if (i == 3) first_word[7:0]   = rx_byte;
         tick();
         if (write_strobe === 1'b1) strobes++;
         if (i == 3) begin
            checks++; if (write_data !== first_word) begin failures++; $display("FAIL timeout_word got=%h exp=%h", write_data, first_word); end
         end
      end
      rx_valid = 1'b0;
      for (int k = 1; k <= 30 && fall_at < 0; k++) begin
         tick();
         if (write_strobe === 1'b1) strobes++;
         if (com_active === 1'b0) fall_at = k;
      end
      checks++; if (fall_at != TO) begin failures++; $display("FAIL timeout_fall got=%0d exp=%0d", fall_at, TO); end
      checks++; if (strobes != 1) begin failures++; $display("FAIL timeout_strobes got=%0d exp=1", strobes); end
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         rx_byte = seq[i]; rx_valid = 1'b1;
         tick();
         checks++; if (write_strobe !== (i == 3)) begin failures++; $display("FAIL realign_strobe byte=%0d got=%b exp=%b", i, write_strobe, (i == 3)); end
      end
      checks++; if (write_data !== 32'h1122_3344) begin failures++; $display("FAIL realign_data got=%h exp=%h", write_data, 32'h1122_3344); end
      rx_valid = 1'b0;
   endtask

   task automatic test_timeout_race();
      logic [31:0] w;
      go_idle();
      w = $urandom;
      rx_byte = w[31:24]; rx_valid = 1'b1; tick();
      rx_valid = 1'b0;
      for (int k = 0; k < TO - 1; k++) tick();
      checks++; if (com_active !== 1'b1) begin failures++; $display("FAIL race_pre_active got=%b exp=1", com_active); end
      rx_byte = w[23:16]; rx_valid = 1'b1; tick();
      checks++; if (com_active !== 1'b1) begin failures++; $display("FAIL race_active got=%b exp=1", com_active); end
      rx_byte = w[15:8]; tick();
      rx_byte = w[7:0]; tick();
      checks++; if (write_strobe !== 1'b1) begin failures++; $display("FAIL race_strobe got=%b exp=1", write_strobe); end
      checks++; if (write_data !== w) begin failures++; $display("FAIL race_data got=%h exp=%h", write_data, w); end
      rx_valid = 1'b0;
   endtask

   task automatic test_word_mode();
      int fall_at;
      fall_at = -1;
      go_idle();
      mode = 1'b1; tick();
      par_word = 32'hDEAD_BEEF; par_strobe = 1'b1; rx_valid = 1'($urandom); rx_byte = 8'($urandom);
      tick();
      checks++; if (write_strobe !== 1'b1 || write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word1 got=%b/%h exp=1/%h", write_strobe, write_data, 32'hDEAD_BEEF); end
      checks++; if (com_active !== 1'b1) begin failures++; $display("FAIL word_active got=%b exp=1", com_active); end
      par_word = 32'h0000_0001; rx_valid = 1'b1;
      tick();
      checks++; if (write_strobe !== 1'b1 || write_data !== 32'h0000_0001) begin failures++; $display("FAIL word2 got=%b/%h exp=1/%h", write_strobe, write_data, 32'h1); end
      par_strobe = 1'b0;
      for (int k = 1; k <= 30 && fall_at < 0; k++) begin
         rx_valid = 1'b1; rx_byte = 8'($urandom);
         tick();
         checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL word_rx_ignored cyc=%0d got=%b exp=0", k, write_strobe); end
         if (com_active === 1'b0) fall_at = k;
      end
      checks++; if (fall_at != TO) begin failures++; $display("FAIL word_fall got=%0d exp=%0d", fall_at, TO); end
      checks++; if (write_data !== 32'h0000_0001) begin failures++; $display("FAIL word_hold got=%h exp=%h", write_data, 32'h1); end
      rx_valid = 1'b0;
   endtask

   task automatic test_random_words();
      for (int c = 0; c < 200; c++) begin
         par_strobe = ($urandom_range(0, 1) == 1);
         par_word   = $urandom;
         rx_valid   = 1'($urandom);
         rx_byte    = 8'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            par_strobe = 1'b0;
            for (int g = 0; g < $urandom_range(12, 20); g++) begin
               tick();
               checks++; if (com_active !== m_active) begin failures++; $display("FAIL rw_gap_active cyc=%0d got=%b exp=%b", c, com_active, m_active); end
            end
         end
         tick();
         checks++; if (write_strobe !== m_strobe) begin failures++; $display("FAIL rw_strobe cyc=%0d got=%b exp=%b", c, write_strobe, m_strobe); end
         checks++; if (write_data !== m_data) begin failures++; $display("FAIL rw_data cyc=%0d got=%h exp=%h", c, write_data, m_data); end
         checks++; if (com_active !== m_active) begin failures++; $display("FAIL rw_active cyc=%0d got=%b exp=%b", c, com_active, m_active); end
         checks++; if (checksum !== exp_chk()) begin failures++; $display("FAIL rw_checksum cyc=%0d got=%h exp=%h", c, checksum, exp_chk()); end
      end
      par_strobe = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic test_reset_midword();
      logic [31:0] w;
      go_idle();
      mode = 1'b0; tick();
      for (int i = 0; i < 2; i++) begin
         rx_byte = 8'($urandom); rx_valid = 1'b1; tick();
      end
      rx_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++; if (com_active !== 1'b0) begin failures++; $display("FAIL midreset_active got=%b exp=0", com_active); end
      checks++; if (write_data !== 32'h0 || write_strobe !== 1'b0) begin failures++; $display("FAIL midreset_out got=%b/%h exp=0/0", write_strobe, write_data); end
      checks++; if (checksum !== 32'h0) begin failures++; $display("FAIL midreset_checksum got=%h exp=0", checksum); end
      model_reset();
      @(posedge clk);
      #3 resetn = 1'b1;
      w = $urandom;
      for (int i = 3; i >= 0; i--) begin
         rx_byte = w[i*8 +: 8]; rx_valid = 1'b1; tick();
      end
      rx_valid = 1'b0;
      checks++; if (write_strobe !== 1'b1 || write_data !== w) begin failures++; $display("FAIL midreset_word got=%b/%h exp=1/%h", write_strobe, write_data, w); end
   endtask

   task automatic test_random_bytes();
      for (int c = 0; c < 300; c++) begin
         rx_valid   = ($urandom_range(0, 9) < 6);
         rx_byte    = 8'($urandom);
         par_strobe = 1'($urandom);
         par_word   = $urandom;
         if ($urandom_range(0, 29) == 0) begin
            rx_valid = 1'b0;
            for (int g = 0; g < $urandom_range(12, 20); g++) begin
               tick();
               checks++; if (com_active !== m_active) begin failures++; $display("FAIL rb_gap_active cyc=%0d got=%b exp=%b", c, com_active, m_active); end
            end
         end
         tick();
         checks++; if (write_strobe !== m_strobe) begin failures++; $display("FAIL rb_strobe cyc=%0d got=%b exp=%b", c, write_strobe, m_strobe); end
         checks++; if (write_data !== m_data) begin failures++; $display("FAIL rb_data cyc=%0d got=%h exp=%h", c, write_data, m_data); end
         checks++; if (com_active !== m_active) begin failures++; $display("FAIL rb_active cyc=%0d got=%b exp=%b", c, com_active, m_active); end
         checks++; if (checksum !== exp_chk()) begin failures++; $display("FAIL rb_checksum cyc=%0d got=%h exp=%h", c, checksum, exp_chk()); end
      end
      rx_valid = 1'b0; par_strobe = 1'b0;
   endtask

   task automatic test_checksum();
      logic [7:0]  seq [4];
      logic [31:0] exp_a;
      logic [31:0] exp_b;
`ifdef CONFIG_CHECKSUM_EN
      exp_a = 32'h105; exp_b = 32'h7;
`else
      exp_a = 32'h0;   exp_b = 32'h0;
`endif
      go_idle();
      seq = '{8'h01, 8'h02, 8'h03, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         rx_byte = seq[i]; rx_valid = 1'b1; tick();
      end
      rx_valid = 1'b0;
      checks++; if (checksum !== exp_a) begin failures++; $display("FAIL chk_sum got=%h exp=%h", checksum, exp_a); end
      go_idle();
      checks++; if (com_active !== 1'b0) begin failures++; $display("FAIL chk_idle got=%b exp=0", com_active); end
      checks++; if (checksum !== exp_a) begin failures++; $display("FAIL chk_held got=%h exp=%h", checksum, exp_a); end
      rx_byte = 8'h07; rx_valid = 1'b1; tick();
      rx_valid = 1'b0;
      checks++; if (checksum !== exp_b) begin failures++; $display("FAIL chk_restart got=%h exp=%h", checksum, exp_b); end
   endtask

   initial begin
      checks = 0; failures = 0;
      mode = 1'b0; rx_byte = 8'h0; rx_valid = 1'b0; par_word = 32'h0; par_strobe = 1'b0;
      model_reset();
      test_reset();
      test_byte_basic();
      test_timeout();
      test_timeout_race();
      test_word_mode();
      test_random_words();
      test_reset_midword();
      test_random_bytes();
      test_checksum();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
